// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with programmable modulus, parallel load,
// wrap/saturate limit handling, a registered limit pulse and sticky flags.
module param_updown_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = (1 << WIDTH) - 1,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_evt,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_evt_q, wrap_evt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             at_max, at_min;

  assign at_max = (count_q == MAX_C);
  assign at_min = (count_q == '0);

  always_comb begin
    count_d    = count_q;
    wrap_evt_d = 1'b0;
    ovf_d      = ovf_q & ~flag_clr;
    unf_d      = unf_q & ~flag_clr;
    if (load) begin
      count_d = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (en) begin
      if (!mode) begin
        // Limit compare precedes the increment so wrap is modulo MAX_VAL+1.
        if (at_max) begin
          count_d    = sat ? MAX_C : '0;
          wrap_evt_d = 1'b1;
          ovf_d      = 1'b1;
        end else begin
          count_d = count_q + ONE_C;
        end
      end else begin
        if (at_min) begin
          count_d    = sat ? '0 : MAX_C;
          wrap_evt_d = 1'b1;
          unf_d      = 1'b1;
        end else begin
          count_d = count_q - ONE_C;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= RST_C;
      wrap_evt_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_evt_q <= wrap_evt_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign count    = count_q;
  assign wrap_evt = wrap_evt_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign tc       = en & (mode ? at_min : at_max);

endmodule
